// File: rtl/nes_pad_responder.sv
// nes_pad_responder: controller-side NES pad emulation (4021-style PISO).
// The host's latch_in and pclk_in are asynchronous. Each one is synchronised,
// edge-detected and then drives a small IDLE/LATCH/SHIFT FSM.
// Optional feature macro: NES_PAD_TURBO_EN adds turbo A/B with a latch-counted phase.
module nes_pad_responder #(
  parameter int   SYNC_STAGES = 2,
  parameter logic FILL        = 1'b1,
  parameter bit   INVERT      = 1'b1,
  parameter int   TURBO_LATCH = 4
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] buttons,
  input  logic       latch_in,
  input  logic       pclk_in,
`ifdef NES_PAD_TURBO_EN
  input  logic [1:0] turbo,
`endif
  output logic       data_out,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, LATCH, SHIFT} state_t;

  // The register stores the logical bit that gives wire level FILL after the optional inversion.
  localparam logic FILL_BIT = INVERT ? ~FILL : FILL;

  state_t                 state, state_n;
  logic [7:0]             sr, sr_n;
  logic [3:0]             bit_cnt, bit_cnt_n;
  logic                   dout_n;
  logic [SYNC_STAGES-1:0] l_sync, p_sync;
  logic                   l_prev, p_prev;
  logic                   l_rise, l_fall, p_rise;
  logic [7:0]             eff_buttons;

  // Synchronisers, plus one extra stage for edge detection. They freeze while en is low.
  always_ff @(posedge CLK) begin
    if (reset) begin
      l_sync <= '0;
      p_sync <= '0;
      l_prev <= 1'b0;
      p_prev <= 1'b0;
    end else if (en) begin
      l_sync <= {l_sync[SYNC_STAGES-2:0], latch_in};
      p_sync <= {p_sync[SYNC_STAGES-2:0], pclk_in};
      l_prev <= l_sync[SYNC_STAGES-1];
      p_prev <= p_sync[SYNC_STAGES-1];
    end
  end

  assign l_rise =  l_sync[SYNC_STAGES-1] & ~l_prev;
  assign l_fall = ~l_sync[SYNC_STAGES-1] &  l_prev;
  assign p_rise =  p_sync[SYNC_STAGES-1] & ~p_prev;

`ifdef NES_PAD_TURBO_EN
  localparam int TW = (TURBO_LATCH < 2) ? 1 : $clog2(TURBO_LATCH);
  logic [TW-1:0] turbo_cnt;
  logic          phase;

  // Turbo phase flips every TURBO_LATCH completed latches (counted on l_fall).
  always_ff @(posedge CLK) begin
    if (reset) begin
      turbo_cnt <= '0;
      phase     <= 1'b0;
    end else if (en && l_fall) begin
      if (turbo_cnt == TW'(TURBO_LATCH - 1)) begin
        turbo_cnt <= '0;
        phase     <= ~phase;
      end else begin
        turbo_cnt <= turbo_cnt + 1'b1;
      end
    end
  end

  assign eff_buttons = {buttons[7:2],
                        buttons[1] & (~turbo[1] | phase),
                        buttons[0] & (~turbo[0] | phase)};
`else
  assign eff_buttons = buttons;
`endif

  // Next-state logic. A latch takes priority over a coincident pulse, and it aborts any frame in progress.
  always_comb begin
    logic load, shift;
    state_n   = state;
    sr_n      = sr;
    bit_cnt_n = bit_cnt;
    load      = 1'b0;
    shift     = 1'b0;
    case (state)
      IDLE: begin
        if (l_rise) begin
          state_n = LATCH;
          load    = 1'b1;
        end
      end
      LATCH: begin
        // Transparent load while latch is high; the snapshot freezes on the fall.
        if (l_fall) state_n = SHIFT;
        else        load    = 1'b1;
      end
      SHIFT: begin
        if (l_rise) begin
          state_n = LATCH;
          load    = 1'b1;
        end else if (p_rise) begin
          shift = 1'b1;
          if (bit_cnt == 4'd7) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (load) begin
      sr_n      = eff_buttons;
      bit_cnt_n = 4'd0;
    end else if (shift) begin
      sr_n      = {FILL_BIT, sr[7:1]};
      bit_cnt_n = (bit_cnt == 4'd8) ? bit_cnt : bit_cnt + 4'd1;
    end
    // data_out only moves when the shifter does, so it stays at FILL after reset and in IDLE.
    dout_n = (load || shift) ? (INVERT ? ~sr_n[0] : sr_n[0]) : data_out;
  end

  // State, shifter and registered serial output.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state    <= IDLE;
      sr       <= '0;
      bit_cnt  <= '0;
      data_out <= FILL;
    end else if (en) begin
      state    <= state_n;
      sr       <= sr_n;
      bit_cnt  <= bit_cnt_n;
      data_out <= dout_n;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_nes_pad_responder.sv
// Self-checking bench for nes_pad_responder at its default parameters.
// Expected wire bits come from a frame model: bit i of the snapshot, then FILL forever.
module tb_nes_pad_responder;

  localparam bit   INV  = 1'b1;
  localparam logic FILL = 1'b1;
  localparam int   TL   = 4;

  logic       CLK = 1'b0;
  logic       reset, en, latch_in, pclk_in;
  logic [7:0] buttons;
  logic       data_out, busy;
`ifdef NES_PAD_TURBO_EN
  logic [1:0] turbo = 2'b00;
`endif

  int checks = 0;
  int errors = 0;

  nes_pad_responder dut (
    .CLK(CLK), .reset(reset), .en(en), .buttons(buttons),
    .latch_in(latch_in), .pclk_in(pclk_in),
`ifdef NES_PAD_TURBO_EN
    .turbo(turbo),
`endif
    .data_out(data_out), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wire level the host should see for frame position i of a snapshot b.
  function automatic logic exp_bit(input logic [7:0] b, input int i);
    if (i < 8) return INV ? ~b[i] : b[i];
    return FILL;
  endfunction

  task automatic wait_n(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic do_latch(input logic [7:0] b);
    buttons  = b;
    latch_in = 1'b1;
    wait_n(6);
    latch_in = 1'b0;
    wait_n(5);
  endtask

  task automatic pulse();
    pclk_in = 1'b1;
    wait_n(4);
    pclk_in = 1'b0;
    wait_n(4);
  endtask

  // Read n positions starting at 'start', then check the position that follows and busy.
  task automatic read_frame(input string tag, input logic [7:0] b, input int start, input int n);
    for (int i = start; i < start + n; i++) begin
      chk(tag, 8'(data_out), 8'(exp_bit(b, i)));
      pulse();
    end
    chk({tag, "_after"}, 8'(data_out), 8'(exp_bit(b, start + n)));
    chk({tag, "_busy"}, 8'(busy), 8'(start + n < 8));
  endtask

  initial begin
    logic [7:0] rb;
    int         np;
    logic       held;
    reset = 1'b1; en = 1'b1; latch_in = 1'b0; pclk_in = 1'b0; buttons = 8'h00;
    wait_n(3);
    reset = 1'b0;
    wait_n(1);
    chk("rst_data", 8'(data_out), 8'(FILL));
    chk("rst_busy", 8'(busy), 8'h0);

    // Basic frame A+Right, then two trailing fill bits.
    do_latch(8'b1000_0001);
    chk("frame81_busy", 8'(busy), 8'h1);
    read_frame("frame81", 8'b1000_0001, 0, 9);

    // Latch latency: busy rises exactly three clocks after latch_in.
    buttons = 8'h01;
    latch_in = 1'b1;
    wait_n(2);
    chk("lat_latch_2", 8'(busy), 8'h0);
    wait_n(1);
    chk("lat_latch_3", 8'(busy), 8'h1);
    wait_n(3);
    latch_in = 1'b0;
    wait_n(5);
    // Pulse latency: data_out changes exactly three clocks after pclk_in.
    pclk_in = 1'b1;
    wait_n(2);
    chk("lat_pclk_2", 8'(data_out), 8'(exp_bit(8'h01, 0)));
    wait_n(1);
    chk("lat_pclk_3", 8'(data_out), 8'(exp_bit(8'h01, 1)));
    wait_n(2);
    pclk_in = 1'b0;
    wait_n(4);

    // Buttons change while latch is high: the last value before the fall wins.
    buttons = 8'h00;
    latch_in = 1'b1;
    wait_n(5);
    buttons = 8'hFF;
    wait_n(5);
    latch_in = 1'b0;
    wait_n(5);
    buttons = 8'h00;
    read_frame("hold_ff", 8'hFF, 0, 8);

    // Partial frame, then a re-latch that must restart cleanly.
    do_latch(8'h5A);
    read_frame("part5a", 8'h5A, 0, 3);
    do_latch(8'h10);
    read_frame("relatch10", 8'h10, 0, 8);

    // Coincident latch and pulse edges: the latch wins and the pulse is dropped.
    do_latch(8'hC3);
    read_frame("pre_coin", 8'hC3, 0, 2);
    buttons = 8'h3C; latch_in = 1'b1; pclk_in = 1'b1;
    wait_n(4);
    pclk_in = 1'b0;
    wait_n(2);
    latch_in = 1'b0;
    wait_n(5);
    read_frame("coin3c", 8'h3C, 0, 8);

    // Reset mid-frame: FILL and idle on the next cycle, then a clean frame.
    do_latch(8'hA5);
    read_frame("pre_rst", 8'hA5, 0, 4);
    reset = 1'b1;
    wait_n(1);
    reset = 1'b0;
    chk("midrst_data", 8'(data_out), 8'(FILL));
    chk("midrst_busy", 8'(busy), 8'h0);
    wait_n(2);
    do_latch(8'h96);
    read_frame("post_rst", 8'h96, 0, 8);

    // en=0 holds the output; the frame resumes when en returns.
    do_latch(8'h6E);
    read_frame("en_a", 8'h6E, 0, 3);
    en = 1'b0;
    wait_n(6);
    chk("en_hold_data", 8'(data_out), 8'(exp_bit(8'h6E, 3)));
    chk("en_hold_busy", 8'(busy), 8'h1);
    en = 1'b1;
    wait_n(2);
    read_frame("en_b", 8'h6E, 3, 5);

    // Randomised frames of random length, including runs past the end of the frame.
    for (int f = 0; f < 20; f++) begin
      rb = 8'($urandom);
      np = int'($urandom_range(0, 11));
      held = 1'b0;
      buttons = 8'($urandom);
      latch_in = 1'b1;
      wait_n(4);
      buttons = rb;
      wait_n(int'($urandom_range(3, 6)));
      latch_in = 1'b0;
      wait_n(5);
      buttons = 8'($urandom);
      read_frame($sformatf("rand%0d", f), rb, 0, np);
      if (held) chk("never", 8'h0, 8'h1);
    end

`ifdef NES_PAD_TURBO_EN
    // Turbo A: the phase starts released and flips every TL latches. B is unaffected.
    reset = 1'b1;
    wait_n(2);
    reset = 1'b0;
    turbo = 2'b01;
    for (int k = 0; k < 4 * TL; k++) begin
      do_latch(8'h03);
      chk($sformatf("turboA%0d", k), 8'(data_out),
          8'(exp_bit({7'd0, ((k / TL) % 2) == 1}, 0)));
      pulse();
      chk($sformatf("turboB%0d", k), 8'(data_out), 8'(exp_bit(8'h02, 1)));
    end
    turbo = 2'b00;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
